// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants for the two-port ram arbiter
// Purpose: FSM state encoding, port identifiers and default ram geometry
//          used by ram_arbiter and ram_arb_pick.
// Ports:   none (package)
package ram_arb_pkg;

    localparam int DEF_ADDR_SIZE = 11;
    localparam int DEF_WORD_SIZE = 9;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WSETUP = 3'd1;
    localparam state_t S_ACCESS = 3'd2;
    localparam state_t S_RWAIT  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational 2-way request picker
// Purpose: chooses which of two pending requests is granted.
//          RAM_ARB_RR_EN defined  : a tie goes to the port not granted last.
//          RAM_ARB_RR_EN undefined: a tie always goes to port 0.
// Ports:
//   req0, req1   in  pending requests
//   last_grant   in  port id granted most recently (only used with RAM_ARB_RR_EN)
//   grant_valid  out at least one request pending
//   grant_id     out port id that wins
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT0;
        if (req0 && req1) begin
`ifdef RAM_ARB_RR_EN
            grant_id = ~last_grant;
`else
            grant_id = PORT0;
`endif
        end else if (req1) begin
            grant_id = PORT1;
        end
    end

`ifndef RAM_ARB_RR_EN
    // Fixed priority has no memory of past grants.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port req/ack arbiter and sequencer for a single-port ram
// Purpose: grants port 0 (CPU) or port 1 (loader) one at a time, sequences the
//          ram (registered read, level-triggered write) and returns read data in
//          a per-port register. Every transaction acks 3 edges after its grant.
//          Optional round-robin tie breaking under RAM_ARB_RR_EN.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1 request, direction, word address, write data
//   ack0, ack1            one-cycle completion pulse
//   rdata0, rdata1        last read result per port
//   busy                  high whenever the FSM is not idle
//   ram_en/we/re/addr/di  ram drive, ram_do ram read data
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AddrSize = DEF_ADDR_SIZE,
    parameter int WordSize = DEF_WORD_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                we0,
    input  logic [AddrSize-1:0] addr0,
    input  logic [WordSize-1:0] wdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [AddrSize-1:0] addr1,
    input  logic [WordSize-1:0] wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [WordSize-1:0] rdata0,
    output logic [WordSize-1:0] rdata1,
    output logic                busy,
    output logic [AddrSize-1:0] ram_addr,
    output logic [WordSize-1:0] ram_di,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ram_re,
    input  logic [WordSize-1:0] ram_do
);

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [AddrSize-1:0] ram_addr_q, ram_addr_d;
    logic [WordSize-1:0] ram_di_q, ram_di_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [WordSize-1:0] rdata0_q, rdata0_d;
    logic [WordSize-1:0] rdata1_q, rdata1_d;
    logic                busy_q, busy_d;

    logic grant_valid;
    logic grant_id;
    logic grant_fire;
    logic last_grant;

`ifdef RAM_ARB_RR_EN
    // Reset value PORT1 makes port 0 win the first tie.
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (grant_fire) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = PORT0;
`endif

    ram_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Requests are only looked at in IDLE, so a held req is never re-granted
    // while its own transaction is still in flight.
    assign grant_fire = (state_q == S_IDLE) && grant_valid;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            port_q     <= PORT0;
            we_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_re_q   <= ram_re_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    // Next state plus the transaction latch taken on the grant edge.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;

        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    port_d     = grant_id;
                    we_d       = grant_id ? we1 : we0;
                    ram_addr_d = grant_id ? addr1 : addr0;
                    ram_di_d   = grant_id ? wdata1 : wdata0;
                    // Writes get a full cycle of address/data setup before
                    // the level-sensitive write enable rises.
                    state_d    = we_d ? S_WSETUP : S_ACCESS;
                end
            end
            S_WSETUP: state_d = S_ACCESS;
            S_ACCESS: state_d = we_q ? S_DONE : S_RWAIT;
            S_RWAIT:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that each one is a flop
    // that is already correct for the cycle the FSM enters.
    always_comb begin
        ram_en_d = (state_d == S_ACCESS);
        ram_we_d = ram_en_d &  we_d;
        ram_re_d = ram_en_d & ~we_d;
        ack0_d   = (state_d == S_DONE) && (port_d == PORT0);
        ack1_d   = (state_d == S_DONE) && (port_d == PORT1);
        busy_d   = (state_d != S_IDLE);
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // ram_do is valid throughout RWAIT; grab it at the closing edge.
        if (state_q == S_RWAIT) begin
            if (port_q == PORT0) begin
                rdata0_d = ram_do;
            end else begin
                rdata1_d = ram_do;
            end
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_re   = ram_re_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a preloaded ram model
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [10:0] addr0 = '0, addr1 = '0;
    logic [8:0]  wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, ram_en, ram_we, ram_re;
    logic [8:0]  rdata0, rdata1, ram_di;
    logic [10:0] ram_addr;
    logic [8:0]  ram_do = '0;

    logic [8:0]  mem [0:2047];

    int errors = 0;
    int checks = 0;
    int re_hi_cnt = 0;
    int we_hi_cnt = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_en(ram_en), .ram_we(ram_we), .ram_re(ram_re), .ram_do(ram_do)
    );

    // Single-port ram: registered read, write while EN&WE.
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_di;
        if (ram_en && ram_re) ram_do <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_re) re_hi_cnt <= re_hi_cnt + 1;
        if (ram_we) we_hi_cnt <= we_hi_cnt + 1;
        if (ram_re && ram_we) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction on port p; lat counts posedges from the sample edge
    // to the first negedge where ack is seen (3 expected).
    task automatic txn(input logic p, input logic w, input logic [10:0] a,
                       input logic [8:0] d, output int lat);
        @(negedge clk);
        if (p == 1'b0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((p == 1'b0) ? ack0 : ack1) break;
        end
        @(posedge clk);
        #1;
        if (p == 1'b0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", int'(ack0 | ack1), 0);
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [10:0] addr;
        logic [8:0]  wdata;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int re0, we0c, acks, winner;
        logic [8:0] exp_r0, exp_r1;
        int exp_win [4];

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h7FF] = 9'h0F0;
        mem[11'h123] = 9'h0AB;
        mem[11'h010] = 9'h111;

        vecs[0] = '{1'b0, 1'b1, 11'h005, 9'h1A5, 9'h000};
        vecs[1] = '{1'b0, 1'b0, 11'h005, 9'h000, 9'h1A5};
        vecs[2] = '{1'b1, 1'b0, 11'h7FF, 9'h000, 9'h0F0};
        vecs[3] = '{1'b1, 1'b1, 11'h000, 9'h1FF, 9'h000};
        vecs[4] = '{1'b0, 1'b0, 11'h000, 9'h000, 9'h1FF};
        vecs[5] = '{1'b1, 1'b0, 11'h123, 9'h000, 9'h0AB};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack", int'(ack0 | ack1), 0);
        chk("reset_ram_en", int'(ram_en | ram_we | ram_re), 0);
        chk("reset_rdata", int'(rdata0 | rdata1), 0);

        // Table-driven transactions
        exp_r0 = '0;
        exp_r1 = '0;
        foreach (vecs[k]) begin
            re0  = re_hi_cnt;
            we0c = we_hi_cnt;
            txn(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata, lat);
            chk($sformatf("vec%0d_latency", k), lat, 3);
            if (!vecs[k].we) begin
                if (vecs[k].port == 1'b0) exp_r0 = vecs[k].exp;
                else exp_r1 = vecs[k].exp;
            end
            chk($sformatf("vec%0d_rdata0", k), int'(rdata0), int'(exp_r0));
            chk($sformatf("vec%0d_rdata1", k), int'(rdata1), int'(exp_r1));
            chk($sformatf("vec%0d_re_cycles", k), re_hi_cnt - re0, vecs[k].we ? 0 : 1);
            chk($sformatf("vec%0d_we_cycles", k), we_hi_cnt - we0c, vecs[k].we ? 1 : 0);
            chk($sformatf("vec%0d_idle", k), int'(busy), 0);
        end

        // Port1 write with a port0 read of the same word queued behind it
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 11'h010; wdata1 = 9'h055;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h010;
        lat = 0;
        for (int i = 0; i < 20 && !ack1; i++) begin @(negedge clk); lat++; end
        chk("wr1_ack_seen", int'(ack1), 1);
        chk("wr1_ack0_quiet", int'(ack0), 0);
        @(posedge clk); #1; req1 = 1'b0;
        for (int i = 0; i < 20 && !ack0; i++) @(negedge clk);
        chk("rd0_after_wr1_ack", int'(ack0), 1);
        chk("rd0_after_wr1_data", int'(rdata0), 9'h055);
        @(posedge clk); #1; req0 = 1'b0;
        @(negedge clk);
        chk("we_re_overlap", overlap_cnt, 0);

        // req0 dropped one cycle after being sampled
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h123;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        lat = 1;
        for (int i = 0; i < 20 && !ack0; i++) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("drop_latency", lat, 3);
        chk("drop_rdata0", int'(rdata0), 9'h0AB);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("drop_no_extra_ack", acks, 0);
        chk("drop_busy", int'(busy), 0);

        // Reset asserted in the middle of a read
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h7FF;
        @(posedge clk); #1;
        chk("midread_ram_en", int'(ram_en), 1);
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("async_ram_en", int'(ram_en | ram_re | ram_we), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ack", int'(ack0 | ack1), 0);
        chk("async_rdata", int'(rdata0 | rdata1), 0);
        chk("async_ram_addr", int'(ram_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("reset_abort_no_ack", acks, 0);

        // Tie arbitration over four rounds, starting from reset
`ifdef RAM_ARB_RR_EN
        exp_win = '{0, 1, 0, 1};
`else
        exp_win = '{0, 0, 0, 0};
`endif
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h005;
        req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF;
        for (int r = 0; r < 4; r++) begin
            winner = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ack0) begin winner = 0; break; end
                if (ack1) begin winner = 1; break; end
            end
            chk($sformatf("tie_round%0d_winner", r), winner, exp_win[r]);
            @(posedge clk); #1;
            if (r == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (winner == 0) req0 = 1'b0;
                if (winner == 1) req1 = 1'b0;
                @(negedge clk);
                req0 = 1'b1; req1 = 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        chk("tie_end_idle", int'(busy), 0);
        chk("tie_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
